// File: rtl/sort_ctrl.sv
// Purpose: sequences one packet into RAM, bubble-sorts it in place (ascending unsigned), streams it out.
// Latency: N load beats, 3 cycles per compare (+1 per swap), output 2 cycles after first read.
// Backpressure: busy_o=1 from the cycle after the accepted eop until eop_o; beats then are dropped.
module sort_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              val_i,
  output logic              busy_o,
  output logic              ram_wren_o,
  output logic [AWIDTH-1:0] ram_wraddr_o,
  output logic [DWIDTH-1:0] ram_wrdata_o,
  output logic [AWIDTH-1:0] ram_rdaddr_o,
  input  logic [DWIDTH-1:0] ram_q_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o
);

  localparam int MAXLEN = 2 ** AWIDTH;
  localparam int LW     = AWIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_A, S_RD_B, S_CMP, S_SWAP, S_OUT
  } state_t;

  // sequencer state
  state_t            r_state;
  logic [AWIDTH-1:0] r_cnt;      // next load address
  logic [LW-1:0]     r_len;      // packet length N (1..MAXLEN)
  logic [AWIDTH-1:0] r_pass;
  logic [AWIDTH-1:0] r_idx;
  logic              r_swapped;
  logic [DWIDTH-1:0] r_a;        // a[i] held across the compare
  logic [LW-1:0]     r_rd_cnt;   // output read pointer

  // output pipeline: stage 1 tags the read in flight, stage 2 is the port
  logic              r_p1_vld;
  logic              r_p1_sop;
  logic              r_p1_eop;
  logic [DWIDTH-1:0] r_data_o;
  logic              r_sop_o;
  logic              r_eop_o;
  logic              r_val_o;

  // next-state values
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] w_cnt_nxt;
  logic [LW-1:0]     w_len_nxt;
  logic [AWIDTH-1:0] w_pass_nxt;
  logic [AWIDTH-1:0] w_idx_nxt;
  logic              w_swapped_nxt;
  logic [DWIDTH-1:0] w_a_nxt;
  logic [LW-1:0]     w_rd_cnt_nxt;

  // combinational RAM/handshake drives before reset gating
  logic              w_busy;
  logic              w_wren;
  logic [AWIDTH-1:0] w_wraddr;
  logic [DWIDTH-1:0] w_wrdata;
  logic [AWIDTH-1:0] w_rdaddr;
  logic              w_issue;

  // end-of-compare bookkeeping shared by CMP (no swap) and SWAP
  logic [AWIDTH-1:0] w_idx_p1;
  logic [LW-1:0]     w_last_i;
  logic              w_pass_last;
  logic              w_a_gt;
  state_t            w_step_state;
  logic [AWIDTH-1:0] w_step_idx;
  logic [AWIDTH-1:0] w_step_pass;
  logic              w_step_swapped;

  assign w_idx_p1    = r_idx + AWIDTH'(1);
  assign w_last_i    = r_len - LW'(2) - {1'b0, r_pass};
  assign w_pass_last = ({1'b0, r_pass} == (r_len - LW'(2)));
  assign w_a_gt      = (r_a > ram_q_i);

  // decide where the sort goes after finishing the current compare
  always_comb begin
    w_step_state   = S_RD_A;
    w_step_idx     = w_idx_p1;
    w_step_pass    = r_pass;
    w_step_swapped = r_swapped;
    if ({1'b0, r_idx} >= w_last_i) begin
      if (!r_swapped || w_pass_last) begin
        w_step_state = S_OUT;
        w_step_idx   = r_idx;
      end else begin
        w_step_pass    = r_pass + AWIDTH'(1);
        w_step_idx     = '0;
        w_step_swapped = 1'b0;
      end
    end
  end

  // next-state and RAM port decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_pass_nxt    = r_pass;
    w_idx_nxt     = r_idx;
    w_swapped_nxt = r_swapped;
    w_a_nxt       = r_a;
    w_rd_cnt_nxt  = '0;
    w_busy        = 1'b0;
    w_wren        = 1'b0;
    w_wraddr      = '0;
    w_wrdata      = '0;
    w_rdaddr      = '0;
    w_issue       = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (val_i && sop_i) begin
          // start (or restart) a packet at address 0
          w_wren    = 1'b1;
          w_wraddr  = '0;
          w_wrdata  = data_i;
          w_rdaddr  = AWIDTH'(1);
          w_cnt_nxt = AWIDTH'(1);
          if (eop_i) begin
            w_len_nxt   = LW'(1);
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else if (val_i && (r_state == S_LOAD)) begin
          w_wren    = 1'b1;
          w_wraddr  = r_cnt;
          w_wrdata  = data_i;
          w_rdaddr  = r_cnt ^ AWIDTH'(1);
          w_cnt_nxt = r_cnt + AWIDTH'(1);
          // a full RAM ends the packet even without eop
          if (eop_i || (r_cnt == AWIDTH'(MAXLEN - 1))) begin
            w_len_nxt     = {1'b0, r_cnt} + LW'(1);
            w_pass_nxt    = '0;
            w_idx_nxt     = '0;
            w_swapped_nxt = 1'b0;
            w_state_nxt   = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        w_busy      = 1'b1;
        w_rdaddr    = r_idx;
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        w_busy      = 1'b1;
        w_rdaddr    = w_idx_p1;
        w_a_nxt     = ram_q_i;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        w_busy   = 1'b1;
        w_rdaddr = w_idx_p1;
        if (w_a_gt) begin
          // smaller word goes down now, larger one in SWAP
          w_wren        = 1'b1;
          w_wraddr      = r_idx;
          w_wrdata      = ram_q_i;
          w_swapped_nxt = 1'b1;
          w_state_nxt   = S_SWAP;
        end else begin
          w_state_nxt   = w_step_state;
          w_idx_nxt     = w_step_idx;
          w_pass_nxt    = w_step_pass;
          w_swapped_nxt = w_step_swapped;
        end
      end
      S_SWAP: begin
        w_busy        = 1'b1;
        w_rdaddr      = r_idx;
        w_wren        = 1'b1;
        w_wraddr      = w_idx_p1;
        w_wrdata      = r_a;
        w_state_nxt   = w_step_state;
        w_idx_nxt     = w_step_idx;
        w_pass_nxt    = w_step_pass;
        w_swapped_nxt = w_step_swapped;
      end
      S_OUT: begin
        w_busy       = 1'b1;
        w_rd_cnt_nxt = r_rd_cnt;
        if (r_rd_cnt < r_len) begin
          w_issue      = 1'b1;
          w_rdaddr     = r_rd_cnt[AWIDTH-1:0];
          w_rd_cnt_nxt = r_rd_cnt + LW'(1);
        end
        if (r_eop_o) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_pass    <= '0;
      r_idx     <= '0;
      r_swapped <= 1'b0;
      r_a       <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_pass    <= w_pass_nxt;
      r_idx     <= w_idx_nxt;
      r_swapped <= w_swapped_nxt;
      r_a       <= w_a_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
    end
  end

  // output pipeline: tag the read, then register RAM data onto the port
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_p1_vld <= 1'b0;
      r_p1_sop <= 1'b0;
      r_p1_eop <= 1'b0;
      r_data_o <= '0;
      r_sop_o  <= 1'b0;
      r_eop_o  <= 1'b0;
      r_val_o  <= 1'b0;
    end else begin
      r_p1_vld <= w_issue;
      r_p1_sop <= w_issue && (r_rd_cnt == '0);
      r_p1_eop <= w_issue && (r_rd_cnt == (r_len - LW'(1)));
      r_data_o <= r_p1_vld ? ram_q_i : '0;
      r_sop_o  <= r_p1_sop;
      r_eop_o  <= r_p1_eop;
      r_val_o  <= r_p1_vld;
    end
  end

  // combinational drives are forced low while reset is held
  assign busy_o       = w_busy & ~srst_i;
  assign ram_wren_o   = w_wren & ~srst_i;
  assign ram_wraddr_o = w_wraddr & {AWIDTH{~srst_i}};
  assign ram_wrdata_o = w_wrdata & {DWIDTH{~srst_i}};
  assign ram_rdaddr_o = w_rdaddr & {AWIDTH{~srst_i}};
  assign data_o       = r_data_o;
  assign sop_o        = r_sop_o;
  assign eop_o        = r_eop_o;
  assign val_o        = r_val_o;

endmodule
